// File: rtl/computer_mmio.sv
// -----------------------------------------------------------------------------
// computer_mmio
//   Program-level simulation top for a small 16-bit-instruction RISC core.
//   Holds the core, a parameter-initialised instruction ROM, a data RAM, a
//   16-byte memory-mapped I/O window, a run-control FSM (RUN/HALTED/TIMEOUT),
//   a free-running RUN cycle counter and a program output register.
//
//   Ports (top):
//     clk         in   1          system clock, all state on posedge
//     rst         in   1          synchronous, active-high reset
//     writeData   out  WIDTH      core store data
//     address     out  WIDTH      core data address
//     memWrite    out  1          core store strobe (before MMIO decode)
//     ioOut       out  WIDTH      last value stored to the OUT register
//     ioValid     out  1          one-cycle pulse when ioOut is updated
//     halted      out  1          program stored to the HALT register
//     timedOut    out  1          watchdog expired before a halt
//     cycleCount  out  CNT_WIDTH  cycles spent in RUN since reset
//
//   MMIO window (byte offsets from MMIO_BASE):
//     0x0 OUT (W)   0x2 CYCLE_LO (R)   0x4 STATUS (R)   0xE HALT (W)
//
//   Core ISA (16-bit words; op[15:12] ra[11:8] rb[7:4] imm8[7:0] imm12[11:0]):
//     0 NOP                       5 ADDI ra, imm8   ra += sext(imm8)
//     1 LI   ra, imm8  sext       6 LW   ra, [rb]
//     2 LUI  ra, imm8  imm8<<8    7 SW   ra, [rb]   mem[rb] = ra
//     3 ORI  ra, imm8  zext       8 JMP  imm12      pc = imm12 * bytes/word
// -----------------------------------------------------------------------------

// Instruction ROM, contents fixed at elaboration by PROGRAM (word i at [i]).
module computer_mmio_imem #(
  parameter int                                 ADDR_BITS = 5,
  parameter logic [(2**ADDR_BITS)-1:0][15:0]    PROGRAM   = '0
) (
  input  logic [ADDR_BITS-1:0] index_i,
  output logic [15:0]          instr_o
);
  assign instr_o = PROGRAM[index_i];
endmodule

// Word-addressed data RAM with combinational read and synchronous write.
module computer_mmio_dmem #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 6
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] index_i,
  input  logic [WIDTH-1:0]     wdata_i,
  output logic [WIDTH-1:0]     rdata_o
);
  logic [WIDTH-1:0] mem_q [2**ADDR_BITS];

  // NOTE: the storage array is deliberately not reset; a reset would turn it
  // into flops instead of RAM. Software must initialise what it reads.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[index_i] <= wdata_i;
  end

  assign rdata_o = mem_q[index_i];
endmodule

// Single-cycle core: one instruction per clock, 16 general registers.
module computer_mmio_cpu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      instr_i,
  input  logic [WIDTH-1:0] read_data_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] address_o,
  output logic [WIDTH-1:0] write_data_o,
  output logic             mem_write_o
);
  localparam int               S    = $clog2(WIDTH / 8);
  localparam logic [WIDTH-1:0] STEP = WIDTH'(WIDTH / 8);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LI   = 4'h1;
  localparam logic [3:0] OP_LUI  = 4'h2;
  localparam logic [3:0] OP_ORI  = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] rf_q [16];

  logic [3:0]       op, ra, rb;
  logic [7:0]       imm8;
  logic [11:0]      imm12;
  logic [WIDTH-1:0] sext8, zext8, rf_wdata;
  logic             rf_we, store;

  assign op    = instr_i[15:12];
  assign ra    = instr_i[11:8];
  assign rb    = instr_i[7:4];
  assign imm8  = instr_i[7:0];
  assign imm12 = instr_i[11:0];
  assign sext8 = {{(WIDTH-8){imm8[7]}}, imm8};
  assign zext8 = WIDTH'(imm8);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path through
    // the block leaves one unassigned, which would infer a latch.
    pc_d     = pc_q + STEP;
    rf_we    = 1'b0;
    rf_wdata = '0;
    store    = 1'b0;
    case (op)
      OP_LI:   begin rf_we = 1'b1; rf_wdata = sext8;              end
      OP_LUI:  begin rf_we = 1'b1; rf_wdata = zext8 << 8;         end
      OP_ORI:  begin rf_we = 1'b1; rf_wdata = rf_q[ra] | zext8;   end
      OP_ADDI: begin rf_we = 1'b1; rf_wdata = rf_q[ra] + sext8;   end
      OP_LW:   begin rf_we = 1'b1; rf_wdata = read_data_i;        end
      OP_SW:   store = 1'b1;
      OP_JMP:  pc_d  = WIDTH'(imm12) << S;
      OP_NOP:  ;
      default: ;
    endcase
  end

  assign pc_o         = pc_q;
  assign address_o    = rf_q[rb];
  assign write_data_o = rf_q[ra];
  // Held in reset the core must not present a store, whatever sits at pc 0.
  assign mem_write_o  = store & ~rst;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge
    // values regardless of statement order.
    if (rst) begin
      pc_q <= '0;
      // The register file is small and cleared so a restart replays a
      // program bit-for-bit.
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      if (rf_we) rf_q[ra] <= rf_wdata;
    end
  end
endmodule

// Top level: core + memories + MMIO + run control.
module computer_mmio #(
  parameter int                                     WIDTH          = 16,
  parameter int                                     IMEM_ADDR_BITS = 5,
  parameter logic [WIDTH-1:0]                       MMIO_BASE      = 16'hFFF0,
  parameter int                                     MAX_CYCLES     = 4096,
  parameter int                                     CNT_WIDTH      = 32,
  parameter logic [(2**IMEM_ADDR_BITS)-1:0][15:0]   PROGRAM        = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [WIDTH-1:0]     writeData,
  output logic [WIDTH-1:0]     address,
  output logic                 memWrite,
  output logic [WIDTH-1:0]     ioOut,
  output logic                 ioValid,
  output logic                 halted,
  output logic                 timedOut,
  output logic [CNT_WIDTH-1:0] cycleCount
);
  localparam int S = $clog2(WIDTH / 8);
  // 64-word data RAM: byte addresses alias every 128 bytes.
  localparam int DMEM_ADDR_BITS = 6;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_HALTED  = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  localparam logic [3:0] OFF_OUT      = 4'h0;
  localparam logic [3:0] OFF_CYCLE_LO = 4'h2;
  localparam logic [3:0] OFF_STATUS   = 4'h4;
  localparam logic [3:0] OFF_HALT     = 4'hE;

  localparam bit                   WD_EN   = (MAX_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] WD_LAST = CNT_WIDTH'(MAX_CYCLES - 1);

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     io_out_q, io_out_d;
  logic                 io_valid_q, io_valid_d;

  logic [WIDTH-1:0] pc, cpu_addr, cpu_wdata, cpu_rdata, dmem_rdata, mmio_rdata;
  logic [15:0]      instr;
  logic             cpu_mem_write, cpu_rst, running;
  logic             mmio_hit, out_store, halt_store, watchdog_fire, dmem_we;
  logic [3:0]       offset;

  assign running = (state_q == ST_RUN);
  // Once stopped the core is held in reset, freezing it at its reset state.
  assign cpu_rst = rst | ~running;

  computer_mmio_cpu #(.WIDTH(WIDTH)) u_cpu (
    .clk          (clk),
    .rst          (cpu_rst),
    .instr_i      (instr),
    .read_data_i  (cpu_rdata),
    .pc_o         (pc),
    .address_o    (cpu_addr),
    .write_data_o (cpu_wdata),
    .mem_write_o  (cpu_mem_write)
  );

  computer_mmio_imem #(.ADDR_BITS(IMEM_ADDR_BITS), .PROGRAM(PROGRAM)) u_imem (
    .index_i (pc[IMEM_ADDR_BITS+S-1:S]),
    .instr_o (instr)
  );

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc[WIDTH-1:IMEM_ADDR_BITS+S], pc[S-1:0]};

  // MMIO decode: the window is the 16-byte block whose upper bits match.
  assign mmio_hit   = (cpu_addr[WIDTH-1:4] == MMIO_BASE[WIDTH-1:4]);
  assign offset     = cpu_addr[3:0];
  assign out_store  = running & cpu_mem_write & mmio_hit & (offset == OFF_OUT);
  assign halt_store = running & cpu_mem_write & mmio_hit & (offset == OFF_HALT);
  assign dmem_we    = running & cpu_mem_write & ~mmio_hit;

  computer_mmio_dmem #(.WIDTH(WIDTH), .ADDR_BITS(DMEM_ADDR_BITS)) u_dmem (
    .clk     (clk),
    .we_i    (dmem_we),
    .index_i (cpu_addr[DMEM_ADDR_BITS+S-1:S]),
    .wdata_i (cpu_wdata),
    .rdata_o (dmem_rdata)
  );

  always_comb begin
    mmio_rdata = '0;
    case (offset)
      OFF_CYCLE_LO: mmio_rdata = cnt_q[WIDTH-1:0];
      OFF_STATUS:   mmio_rdata = {{(WIDTH-2){1'b0}}, timedOut, halted};
      default:      mmio_rdata = '0;
    endcase
  end

  assign cpu_rdata = mmio_hit ? mmio_rdata : dmem_rdata;

  // Watchdog fires on the edge that would take the count to MAX_CYCLES.
  assign watchdog_fire = WD_EN && (cnt_q == WD_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        // A HALT store in the last allowed cycle takes priority.
        if (halt_store)         state_d = ST_HALTED;
        else if (watchdog_fire) state_d = ST_TIMEOUT;
      end
      default: state_d = state_q;
    endcase
  end

  assign cnt_d      = running ? cnt_q + 1'b1 : cnt_q;
  assign io_out_d   = out_store ? cpu_wdata : io_out_q;
  assign io_valid_d = out_store;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      io_out_q   <= '0;
      io_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      io_out_q   <= io_out_d;
      io_valid_q <= io_valid_d;
    end
  end

  assign writeData  = cpu_wdata;
  assign address    = cpu_addr;
  assign memWrite   = cpu_mem_write;
  assign ioOut      = io_out_q;
  assign ioValid    = io_valid_q;
  assign halted     = (state_q == ST_HALTED);
  assign timedOut   = (state_q == ST_TIMEOUT);
  assign cycleCount = cnt_q;
endmodule

// File: tb/tb_computer_mmio.sv
// -----------------------------------------------------------------------------
// tb_computer_mmio
//   Directed bench for computer_mmio. Six instances each carry one small
//   program; each is held in reset until its test. Outputs are sampled on the
//   falling edge, where the combinational store strobe shows the instruction
//   executing with cycleCount equal to its index (single-cycle core).
//   Instances: 0 OUT+HALT, 1 watchdog loop, 2 alias/CYCLE_LO/STATUS,
//              3 HALT on last cycle, 4 restart loop, 5 HALT one cycle late.
// -----------------------------------------------------------------------------
module tb_computer_mmio;
  localparam int N = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] rst_v;
  logic [15:0]  wd_v [N], addr_v [N], ioout_v [N];
  logic         mw_v [N], iov_v [N], halt_v [N], to_v [N];
  logic [31:0]  cnt_v [N];

  // store 0x1234 to OUT, then store to HALT
  localparam logic [31:0][15:0] P_A = '{0: 16'h2112, 1: 16'h3134, 2: 16'h12F0,
    3: 16'h7120, 4: 16'h13FE, 5: 16'h7330, default: 16'h0000};
  // r1=0x20; loop { store r1 -> [0x20] }
  localparam logic [31:0][15:0] P_B = '{0: 16'h1120, 1: 16'h7110, 2: 16'h8001,
    default: 16'h0000};
  // clear dmem[0x70]; OUT=0xBEEF; read back 0x70; read CYCLE_LO at cycle 10
  // and STATUS at 11; echo the loads as stores to 0x70; halt at cycle 15
  localparam logic [31:0][15:0] P_C = '{0: 16'h1170, 1: 16'h7010, 2: 16'h22BE,
    3: 16'h32EF, 4: 16'h13F0, 5: 16'h7230, 6: 16'h6410, 7: 16'h7410,
    8: 16'h15F2, 9: 16'h16F4, 10: 16'h6750, 11: 16'h6860, 12: 16'h7710,
    13: 16'h7810, 14: 16'h19FE, 15: 16'h7990, default: 16'h0000};
  // HALT store at instruction 7 (== MAX_CYCLES-1 with MAX_CYCLES=8)
  localparam logic [31:0][15:0] P_D = '{0: 16'h11FE, 7: 16'h7110, default: 16'h0000};
  // OUT = 1,2,3,... every third cycle forever
  localparam logic [31:0][15:0] P_E = '{0: 16'h11F0, 1: 16'h1201, 2: 16'h7210,
    3: 16'h5201, 4: 16'h8002, default: 16'h0000};
  // HALT store at instruction 8, one cycle after the watchdog
  localparam logic [31:0][15:0] P_F = '{0: 16'h11FE, 8: 16'h7110, default: 16'h0000};

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam logic [31:0][15:0] PROG = (g == 0) ? P_A : (g == 1) ? P_B :
                                         (g == 2) ? P_C : (g == 3) ? P_D :
                                         (g == 4) ? P_E : P_F;
    localparam int MC = (g == 1) ? 50 : (g == 3 || g == 5) ? 8 : (g == 4) ? 0 : 4096;
    computer_mmio #(
      .WIDTH(16), .IMEM_ADDR_BITS(5), .MMIO_BASE(16'hFFF0),
      .MAX_CYCLES(MC), .CNT_WIDTH(32), .PROGRAM(PROG)
    ) u_dut (
      .clk        (clk),
      .rst        (rst_v[g]),
      .writeData  (wd_v[g]),
      .address    (addr_v[g]),
      .memWrite   (mw_v[g]),
      .ioOut      (ioout_v[g]),
      .ioValid    (iov_v[g]),
      .halted     (halt_v[g]),
      .timedOut   (to_v[g]),
      .cycleCount (cnt_v[g])
    );
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] st_addr [$];
  logic [15:0] st_data [$];
  logic [31:0] st_cnt  [$];
  logic [15:0] out_vals [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    st_addr.delete();
    st_data.delete();
    st_cnt.delete();
    out_vals.delete();
  endtask

  // Called on a falling edge; leaves reset low on a falling edge.
  task automatic release_rst(input int k, input int hold);
    rst_v[k] = 1'b1;
    repeat (hold) @(negedge clk);
    rst_v[k] = 1'b0;
  endtask

  // Log stores and OUT pulses of instance k for up to `budget` cycles.
  task automatic run(input int k, input int budget, input bit stop_when_done,
                     output int used);
    used = 0;
    for (int i = 0; i < budget; i++) begin
      if (stop_when_done && (halt_v[k] || to_v[k])) break;
      if (mw_v[k]) begin
        st_addr.push_back(addr_v[k]);
        st_data.push_back(wd_v[k]);
        st_cnt.push_back(cnt_v[k]);
      end
      if (iov_v[k]) out_vals.push_back(ioout_v[k]);
      @(negedge clk);
      used++;
    end
  endtask

  task automatic check_store(input string tag, input int idx, input logic [31:0] cyc,
                             input logic [15:0] addr, input logic [15:0] data);
    if (idx >= st_addr.size()) begin
      check({tag, "_present"}, 32'(st_addr.size()), 32'(idx + 1));
    end else begin
      check({tag, "_cycle"}, st_cnt[idx], cyc);
      check({tag, "_addr"}, 32'(st_addr[idx]), 32'(addr));
      check({tag, "_data"}, 32'(st_data[idx]), 32'(data));
    end
  endtask

  task automatic check_reset_state(input string tag, input int k);
    check({tag, "_ioOut"}, 32'(ioout_v[k]), 32'h0);
    check({tag, "_ioValid"}, 32'(iov_v[k]), 32'h0);
    check({tag, "_halted"}, 32'(halt_v[k]), 32'h0);
    check({tag, "_timedOut"}, 32'(to_v[k]), 32'h0);
    check({tag, "_cycleCount"}, cnt_v[k], 32'h0);
    check({tag, "_memWrite"}, 32'(mw_v[k]), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL tb_time_limit: got simulation still running, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int used;
    rst_v = '1;
    @(negedge clk);

    // 1: OUT store then HALT
    release_rst(0, 2);
    check_reset_state("t1_rst", 0);
    clear_log();
    run(0, 100, 1'b1, used);
    check("t1_halted", 32'(halt_v[0]), 32'h1);
    check("t1_timedOut", 32'(to_v[0]), 32'h0);
    check("t1_cycleCount", cnt_v[0], 32'd6);
    check("t1_ioOut", 32'(ioout_v[0]), 32'h1234);
    check("t1_pulses", 32'(out_vals.size()), 32'd1);
    check_store("t1_out", 0, 32'd3, 16'hFFF0, 16'h1234);
    check_store("t1_halt", 1, 32'd5, 16'hFFFE, 16'hFFFE);
    clear_log();
    run(0, 5, 1'b0, used);
    check("t1_frozen_count", cnt_v[0], 32'd6);
    check("t1_post_stores", 32'(st_addr.size()), 32'd0);
    check("t1_post_pulses", 32'(out_vals.size()), 32'd0);
    check("t1_still_halted", 32'(halt_v[0]), 32'h1);

    // 2: infinite loop hits the watchdog at 50
    release_rst(1, 2);
    clear_log();
    run(1, 200, 1'b1, used);
    check("t2_timedOut", 32'(to_v[1]), 32'h1);
    check("t2_halted", 32'(halt_v[1]), 32'h0);
    check("t2_cycleCount", cnt_v[1], 32'd50);
    check("t2_run_cycles", 32'(used), 32'd50);
    clear_log();
    run(1, 10, 1'b0, used);
    check("t2_post_stores", 32'(st_addr.size()), 32'd0);
    check("t2_frozen_count", cnt_v[1], 32'd50);

    // 3+4: MMIO store does not reach the dmem alias; CYCLE_LO and STATUS reads
    release_rst(2, 2);
    clear_log();
    run(2, 100, 1'b1, used);
    check("t3_halted", 32'(halt_v[2]), 32'h1);
    check("t3_cycleCount", cnt_v[2], 32'd16);
    check("t3_ioOut", 32'(ioout_v[2]), 32'hBEEF);
    check("t3_pulses", 32'(out_vals.size()), 32'd1);
    check("t3_store_count", 32'(st_addr.size()), 32'd6);
    check_store("t3_clear", 0, 32'd1, 16'h0070, 16'h0000);
    check_store("t3_out", 1, 32'd5, 16'hFFF0, 16'hBEEF);
    check_store("t3_alias_read", 2, 32'd7, 16'h0070, 16'h0000);
    check_store("t4_cycle_lo", 3, 32'd12, 16'h0070, 16'h000A);
    check_store("t4_status", 4, 32'd13, 16'h0070, 16'h0000);
    check_store("t3_halt", 5, 32'd15, 16'hFFFE, 16'hFFFE);

    // 5: HALT on cycle MAX_CYCLES-1 beats the watchdog; one cycle later loses
    release_rst(3, 2);
    clear_log();
    run(3, 50, 1'b1, used);
    check("t5_halted", 32'(halt_v[3]), 32'h1);
    check("t5_timedOut", 32'(to_v[3]), 32'h0);
    check("t5_cycleCount", cnt_v[3], 32'd8);
    release_rst(5, 2);
    clear_log();
    run(5, 50, 1'b1, used);
    check("t5b_halted", 32'(halt_v[5]), 32'h0);
    check("t5b_timedOut", 32'(to_v[5]), 32'h1);
    check("t5b_cycleCount", cnt_v[5], 32'd8);
    check("t5b_stores", 32'(st_addr.size()), 32'd0);

    // 6: reset mid-loop restarts the program from scratch
    release_rst(4, 1);
    check_reset_state("t6_rst", 4);
    clear_log();
    run(4, 20, 1'b0, used);
    check("t6_run1_count", cnt_v[4], 32'd20);
    check("t6_run1_pulses", 32'(out_vals.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < out_vals.size())
        check($sformatf("t6_run1_out%0d", i), 32'(out_vals[i]), 32'(i + 1));
    rst_v[4] = 1'b1;
    @(negedge clk);
    check_reset_state("t6_mid_rst", 4);
    rst_v[4] = 1'b0;
    clear_log();
    run(4, 20, 1'b0, used);
    check("t6_run2_count", cnt_v[4], 32'd20);
    check("t6_run2_pulses", 32'(out_vals.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < out_vals.size())
        check($sformatf("t6_run2_out%0d", i), 32'(out_vals[i]), 32'(i + 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
